// File: rtl/spike_word_packer.sv
// Spike word packer: gathers SPIKES_PER_WORD per-neuron spike vectors into
// one wide word, tags the word that closes a row, and buffers finished words
// in a first-word-fall-through FIFO feeding a valid/ready stream.
module spike_word_packer #(
  parameter int TIME_STEPS      = 4,
  parameter int SPIKES_PER_WORD = 16,
  parameter int OUT_WIDTH       = TIME_STEPS * SPIKES_PER_WORD,
  parameter int ROW_LEN         = 384,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          s_clk,
  input  logic                          s_rst,
  input  logic                          i_clear,
  input  logic [TIME_STEPS-1:0]         i_spikes,
  input  logic                          i_spikes_valid,
  output logic [OUT_WIDTH-1:0]          o_word,
  output logic                          o_word_last,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic [15:0]                   o_row_idx,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int LANE_W = (SPIKES_PER_WORD > 1) ? $clog2(SPIKES_PER_WORD) : 1;
  localparam int NRN_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } entry_t;

  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [NRN_W-1:0]     nrn_q, nrn_d;
  logic [15:0]          row_q, row_d;
  logic [OUT_WIDTH-1:0] pack_q, pack_d, word_new;
  logic                 row_end, push_req;

  entry_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 ovf_q;
  logic                 pop, full, push, drop;
  entry_t               head;

  // Lane insertion, word completion and row/neuron bookkeeping.
  always_comb begin
    pack_d   = pack_q;
    lane_d   = lane_q;
    nrn_d    = nrn_q;
    row_d    = row_q;
    push_req = 1'b0;
    word_new = pack_q;
    row_end  = (nrn_q == NRN_W'(ROW_LEN - 1));
    for (int k = 0; k < SPIKES_PER_WORD; k++) begin
      if (lane_q == LANE_W'(k)) word_new[k*TIME_STEPS +: TIME_STEPS] = i_spikes;
    end
    if (i_spikes_valid) begin
      // A full word or a row end closes the word; unwritten lanes stay zero.
      if (lane_q == LANE_W'(SPIKES_PER_WORD - 1) || row_end) begin
        push_req = 1'b1;
        pack_d   = '0;
        lane_d   = '0;
      end else begin
        pack_d = word_new;
        lane_d = lane_q + 1'b1;
      end
      if (row_end) begin
        nrn_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        nrn_d = nrn_q + 1'b1;
      end
    end
  end

  // Pack register and counters; clear wins over any same-cycle input.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      lane_q <= '0;
      nrn_q  <= '0;
      row_q  <= '0;
      pack_q <= '0;
    end else if (i_clear) begin
      lane_q <= '0;
      nrn_q  <= '0;
      row_q  <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      nrn_q  <= nrn_d;
      row_q  <= row_d;
      pack_q <= pack_d;
    end
  end

  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  always_comb begin
    pop  = (level_q != '0) && i_word_ready;
    full = (level_q == LVL_W'(FIFO_DEPTH));
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage array; contents are don't-care until the level says otherwise.
  always_ff @(posedge s_clk) begin
    if (push && !i_clear) mem_q[wr_ptr_q] <= '{last: row_end, data: word_new};
  end

  assign head         = mem_q[rd_ptr_q];
  assign o_word_valid = (level_q != '0);
  assign o_word       = o_word_valid ? head.data : '0;
  assign o_word_last  = o_word_valid ? head.last : 1'b0;
  assign o_row_idx    = row_q;
  assign o_fifo_level = level_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_spike_word_packer.sv
// Bench for spike_word_packer: queue-based reference model updated on every
// clock/reset edge, a per-cycle output compare, directed literal checks and a
// randomized soak.
module tb_spike_word_packer;

  localparam int TS    = 4;
  localparam int SPW   = 16;
  localparam int OW    = 64;
  localparam int RL    = 20;
  localparam int DEPTH = 8;

  logic          s_clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          i_clear = 1'b0;
  logic [TS-1:0] i_spikes = '0;
  logic          i_spikes_valid = 1'b0;
  logic          i_word_ready = 1'b0;
  logic [OW-1:0] o_word;
  logic          o_word_last, o_word_valid, o_overflow;
  logic [15:0]   o_row_idx;
  logic [3:0]    o_fifo_level;

  int total = 0;
  int bad   = 0;

  spike_word_packer #(.ROW_LEN(RL)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_clear(i_clear),
    .i_spikes(i_spikes), .i_spikes_valid(i_spikes_valid),
    .o_word(o_word), .o_word_last(o_word_last), .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready), .o_row_idx(o_row_idx),
    .o_fifo_level(o_fifo_level), .o_overflow(o_overflow)
  );

  always #5 s_clk = ~s_clk;

  // ---------------- reference model ----------------
  logic [TS-1:0] m_part[$];
  logic [OW:0]   m_q[$];
  int            m_nrn  = 0;
  logic [15:0]   m_rows = '0;
  bit            m_ovf  = 1'b0;
  int            m_comp = 0;

  task automatic model_clear();
    m_part.delete();
    m_q.delete();
    m_nrn  = 0;
    m_rows = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    logic [OW-1:0] w;
    bit            last;
    if (s_rst || i_clear) begin
      model_clear();
      return;
    end
    if (m_q.size() > 0 && i_word_ready) void'(m_q.pop_front());
    if (i_spikes_valid) begin
      last = (m_nrn == RL - 1);
      m_part.push_back(i_spikes);
      if (m_part.size() == SPW || last) begin
        w = '0;
        foreach (m_part[k]) w[k*TS +: TS] = m_part[k];
        if (m_q.size() < DEPTH) m_q.push_back({last, w});
        else m_ovf = 1'b1;
        m_part.delete();
        m_comp++;
      end
      if (last) begin
        m_nrn  = 0;
        m_rows = m_rows + 16'd1;
      end else begin
        m_nrn = m_nrn + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge s_clk or posedge s_rst);
    model_step();
  end

  task automatic chk(string nm, logic [OW-1:0] got, logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge s_clk);
    chk("valid", OW'(o_word_valid), OW'(m_q.size() != 0));
    chk("level", OW'(o_fifo_level), OW'(m_q.size()));
    chk("ovf",   OW'(o_overflow),   OW'(m_ovf));
    chk("row",   OW'(o_row_idx),    OW'(m_rows));
    if (m_q.size() != 0) begin
      chk("word", o_word, m_q[0][OW-1:0]);
      chk("last", OW'(o_word_last), OW'(m_q[0][OW]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit v, logic [TS-1:0] s, bit r, bit c = 1'b0);
    i_spikes_valid = v;
    i_spikes       = s;
    i_word_ready   = r;
    i_clear        = c;
    @(posedge s_clk);
    #1;
    i_clear = 1'b0;
  endtask

  initial begin
    int guard;
    // reset state
    repeat (2) @(posedge s_clk);
    #1;
    chk("rst_valid", OW'(o_word_valid), '0);
    chk("rst_word",  o_word, '0);
    chk("rst_level", OW'(o_fifo_level), '0);
    chk("rst_row",   OW'(o_row_idx), '0);
    chk("rst_ovf",   OW'(o_overflow), '0);
    s_rst = 1'b0;

    // 16 neurons carrying their own index, downstream always ready
    for (int n = 0; n < 16; n++) begin
      cyc(1'b1, TS'(n), 1'b1);
      if (n == 14) chk("t1_not_yet", OW'(o_word_valid), '0);
    end
    chk("t1_valid", OW'(o_word_valid), 1);
    chk("t1_word",  o_word, 64'hFEDC_BA98_7654_3210);
    chk("t1_last",  OW'(o_word_last), 0);
    cyc(1'b0, '0, 1'b1);
    chk("t1_drained", OW'(o_fifo_level), 0);

    // one 20-neuron row of all-ones, held in the FIFO
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < RL; n++) cyc(1'b1, 4'hF, 1'b0);
    chk("t2_level", OW'(o_fifo_level), 2);
    chk("t2_w0",    o_word, {OW{1'b1}});
    chk("t2_l0",    OW'(o_word_last), 0);
    chk("t2_row",   OW'(o_row_idx), 1);
    cyc(1'b0, '0, 1'b1);
    chk("t2_w1",    o_word, 64'h0000_0000_0000_FFFF);
    chk("t2_l1",    OW'(o_word_last), 1);
    cyc(1'b0, '0, 1'b1);

    // fill past capacity with the sink stalled, then drain in order
    cyc(1'b0, '0, 1'b0, 1'b1);
    guard = m_comp;
    for (int i = 0; i < 400 && m_comp < guard + 9; i++) cyc(1'b1, TS'($urandom), 1'b0);
    chk("t3_comp",  OW'(m_comp - guard), 9);
    chk("t3_level", OW'(o_fifo_level), 8);
    chk("t3_ovf",   OW'(o_overflow), 1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    chk("t3_empty", OW'(o_fifo_level), 0);
    chk("t3_ovf_sticky", OW'(o_overflow), 1);

    // full FIFO with push and pop on the same edge
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 400 && m_q.size() < DEPTH; i++) cyc(1'b1, TS'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (m_part.size() == SPW - 1 || m_nrn == RL - 1) begin
        cyc(1'b1, TS'($urandom), 1'b1);
        break;
      end
      cyc(1'b1, TS'($urandom), 1'b0);
    end
    chk("t4_level", OW'(o_fifo_level), 8);
    chk("t4_ovf",   OW'(o_overflow), 0);

    // continuous input with ready toggling every cycle
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) cyc(1'b1, TS'($urandom), i[0]);
    chk("t5_ovf", OW'(o_overflow), 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);

    // reset in the middle of a word
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 7; n++) cyc(1'b1, 4'hA, 1'b1);
    #2 s_rst = 1'b1;
    #1;
    chk("t6_rst_level", OW'(o_fifo_level), 0);
    chk("t6_rst_row",   OW'(o_row_idx), 0);
    @(posedge s_clk);
    #1 s_rst = 1'b0;
    for (int n = 0; n < 16; n++) cyc(1'b1, TS'(n), 1'b0);
    chk("t6_word", o_word, 64'hFEDC_BA98_7654_3210);
    chk("t6_last", OW'(o_word_last), 0);
    chk("t6_level", OW'(o_fifo_level), 1);

    // randomized soak with varying sink pressure and rare clears
    for (int seg = 0; seg < 6; seg++) begin
      int rpct = $urandom_range(5, 95);
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(0, 3) != 0, TS'($urandom),
            $urandom_range(0, 99) < rpct, $urandom_range(0, 499) == 0);
    end

    @(negedge s_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
